// File: rtl/acc_unit_pkg.sv
// Shared opcode and state encodings for the parametrised 8051 accumulator.
package acc_unit_pkg;

    localparam int ACCU_OP_LEN = 4;

    typedef enum logic [ACCU_OP_LEN-1:0] {
        ACCU_OP_NOP     = 4'd0,
        ACCU_OP_WR      = 4'd1,
        ACCU_OP_WR_BIT  = 4'd2,
        ACCU_OP_CLR     = 4'd3,
        ACCU_OP_CPL     = 4'd4,
        ACCU_OP_INC     = 4'd5,
        ACCU_OP_DEC     = 4'd6,
        ACCU_OP_RL      = 4'd7,
        ACCU_OP_RR      = 4'd8,
        ACCU_OP_RLC     = 4'd9,
        ACCU_OP_RRC     = 4'd10,
        ACCU_OP_SWAP    = 4'd11,
        ACCU_OP_ROTL_N  = 4'd12,
        ACCU_OP_ROTR_N  = 4'd13,
        ACCU_OP_CPL_BIT = 4'd14,
        ACCU_OP_RSVD    = 4'd15
    } accu_op_e;

    typedef enum logic {
        ACCU_ST_IDLE = 1'b0,
        ACCU_ST_ROT  = 1'b1
    } accu_st_e;

endpackage

// File: rtl/acc_unit_if.sv
// Request/response bundle between the core sequencer and the accumulator.
interface acc_unit_if #(parameter int WIDTH = 8);
    logic             i_valid;
    logic             o_ready;
    logic [3:0]       i_op;
    logic [WIDTH-1:0] i_data;
    logic             i_cy;
    logic [WIDTH-1:0] o_acc;
    logic             o_parity;
    logic             o_zero;
    logic             o_cy;
    logic             o_cy_we;
    logic             o_done;

    modport master (
        output i_valid, i_op, i_data, i_cy,
        input  o_ready, o_acc, o_parity, o_zero, o_cy, o_cy_we, o_done
    );

    modport slave (
        input  i_valid, i_op, i_data, i_cy,
        output o_ready, o_acc, o_parity, o_zero, o_cy, o_cy_we, o_done
    );
endinterface

// File: rtl/acc_unit_rot1.sv
// Combinational single-bit rotator; dir=0 rotates left, dir=1 rotates right.
// With through_carry the vacated bit comes from cy_in instead of wrapping.
module acc_rot1 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir,
    input  logic             through_carry,
    input  logic             cy_in,
    output logic [WIDTH-1:0] value_out,
    output logic             cy_out
);
    logic fill;

    always_comb begin
        fill      = 1'b0;
        value_out = value;
        cy_out    = 1'b0;
        if (!dir) begin
            fill      = through_carry ? cy_in : value[WIDTH-1];
            value_out = {value[WIDTH-2:0], fill};
            cy_out    = value[WIDTH-1];
        end else begin
            fill      = through_carry ? cy_in : value[0];
            value_out = {fill, value[WIDTH-1:1]};
            cy_out    = value[0];
        end
    end
endmodule

// File: rtl/acc_unit.sv
// Parametrised 8051 accumulator: single-cycle ALU-style ops plus a
// multi-cycle rotate-by-N that holds off new requests while it runs.
module acc_unit
    import acc_unit_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = '0,
    parameter int          IDX_W     = $clog2(WIDTH)
) (
    input  logic   i_clk,
    input  logic   i_rst,
    acc_unit_if.slave bus
);
    accu_st_e         state, state_nx;
    accu_op_e         op;
    logic [WIDTH-1:0] acc, acc_nx, rot_out;
    logic [IDX_W-1:0] count, count_nx, rot_n, bit_idx;
    logic             dir, dir_nx;
    logic             cy, cy_nx, cy_we, cy_we_nx, done, done_nx;
    logic             accept, rot_dir, rot_thru, rot_cy;

    assign op      = accu_op_e'(bus.i_op);
    assign bit_idx = bus.i_data[IDX_W:1];
    assign rot_n   = bus.i_data[IDX_W-1:0];
    assign accept  = bus.i_valid && (state == ACCU_ST_IDLE);

    // In ROT the rotator follows the latched direction, not the live opcode.
    assign rot_dir  = (state == ACCU_ST_ROT) ? dir :
                      (op == ACCU_OP_RR || op == ACCU_OP_RRC || op == ACCU_OP_ROTR_N);
    assign rot_thru = (state == ACCU_ST_IDLE) && (op == ACCU_OP_RLC || op == ACCU_OP_RRC);

    acc_rot1 #(.WIDTH(WIDTH)) u_rot1 (
        .value         (acc),
        .dir           (rot_dir),
        .through_carry (rot_thru),
        .cy_in         (bus.i_cy),
        .value_out     (rot_out),
        .cy_out        (rot_cy)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ACCU_ST_IDLE;
            acc   <= RESET_VAL[WIDTH-1:0];
            count <= '0;
            dir   <= 1'b0;
            cy    <= 1'b0;
            cy_we <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            count <= count_nx;
            dir   <= dir_nx;
            cy    <= cy_nx;
            cy_we <= cy_we_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        count_nx = count;
        dir_nx   = dir;
        cy_nx    = cy;
        cy_we_nx = 1'b0;
        done_nx  = 1'b0;
        case (state)
            ACCU_ST_IDLE: begin
                if (accept) begin
                    done_nx = 1'b1;
                    case (op)
                        ACCU_OP_WR:      acc_nx = bus.i_data;
                        ACCU_OP_WR_BIT:  acc_nx[bit_idx] = bus.i_data[0];
                        ACCU_OP_CLR:     acc_nx = '0;
                        ACCU_OP_CPL:     acc_nx = ~acc;
                        ACCU_OP_INC:     acc_nx = acc + WIDTH'(1);
                        ACCU_OP_DEC:     acc_nx = acc - WIDTH'(1);
                        ACCU_OP_RL,
                        ACCU_OP_RR:      acc_nx = rot_out;
                        ACCU_OP_RLC,
                        ACCU_OP_RRC: begin
                            acc_nx   = rot_out;
                            cy_nx    = rot_cy;
                            cy_we_nx = 1'b1;
                        end
                        ACCU_OP_SWAP:    acc_nx = {acc[WIDTH/2-1:0], acc[WIDTH-1:WIDTH/2]};
                        ACCU_OP_ROTL_N,
                        ACCU_OP_ROTR_N: begin
                            dir_nx = (op == ACCU_OP_ROTR_N);
                            // First bit moves on the accept edge; N=1 finishes here.
                            if (rot_n != '0) begin
                                acc_nx   = rot_out;
                                count_nx = rot_n - IDX_W'(1);
                                if (rot_n != IDX_W'(1)) begin
                                    state_nx = ACCU_ST_ROT;
                                    done_nx  = 1'b0;
                                end
                            end
                        end
                        ACCU_OP_CPL_BIT: acc_nx[bit_idx] = ~acc[bit_idx];
                        default: ;
                    endcase
                end
            end
            ACCU_ST_ROT: begin
                acc_nx   = rot_out;
                count_nx = count - IDX_W'(1);
                if (count == IDX_W'(1)) begin
                    state_nx = ACCU_ST_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ACCU_ST_IDLE;
        endcase
    end

    assign bus.o_acc    = acc;
    assign bus.o_parity = ^acc;
    assign bus.o_zero   = (acc == '0);
    assign bus.o_ready  = (state == ACCU_ST_IDLE);
    assign bus.o_cy     = cy;
    assign bus.o_cy_we  = cy_we;
    assign bus.o_done   = done;
endmodule
